// File: rtl/lcd_char_writer_if.sv
// ----------------------------------------------------------------------------
// lcd_char_writer_if
// Byte write channel into the LCD character writer.
//   iValid  : producer has a byte to write; qualifies iRS and iData
//   iRS     : register select for the byte (0 = command, 1 = character data)
//   iData   : byte to write
//   oReady  : writer can take a byte this cycle
// master = producer side, slave = lcd_char_writer side.
// ----------------------------------------------------------------------------
interface lcd_char_writer_if;
    logic       iValid;
    logic       iRS;
    logic [7:0] iData;
    logic       oReady;

    modport master (output iValid, output iRS, output iData, input oReady);
    modport slave  (input iValid, input iRS, input iData, output oReady);
endinterface

// File: rtl/lcd_char_writer.sv
// ----------------------------------------------------------------------------
// lcd_char_writer
// Drives a 4-bit HD44780-compatible character LCD (write only). After reset it
// waits for the panel to power up, runs the 4-bit init handshake (0x3,0x3,0x3,
// 0x2) and the configuration bytes (0x28,0x06,0x0C,0x01), then accepts one
// byte at a time over a valid/ready channel and sends it as two nibbles.
//
// Ports
//   Clock, Reset             : clock, synchronous active-high reset
//   bus (slave)              : iValid/iRS/iData in, oReady out
//   oInitDone                : init + configuration finished (sticky until Reset)
//   oLCD_Enabled             : LCD E strobe
//   oLCD_RegisterSelect      : LCD RS
//   oLCD_StrataFlashControl  : SF_CE0, held at 1 so the flash stays off the bus
//   oLCD_ReadWrite           : LCD R/W, held at 0
//   oLCD_Data                : LCD DB[7:4]
//
// Every nibble goes through the same micro-sequence: SETUP (2 cycles, E=0),
// PULSE (P_E_PULSE cycles, E=1), HOLD (1 cycle, E=0), then a wait whose length
// depends on which step just finished. RS/data are registered and only loaded
// on entry to SETUP, so they are stable for the whole E pulse.
// ----------------------------------------------------------------------------
module lcd_char_writer #(
    parameter int unsigned P_POWERUP    = 750000,
    parameter int unsigned P_INIT_LONG  = 205000,
    parameter int unsigned P_INIT_SHORT = 5000,
    parameter int unsigned P_CMD_WAIT   = 2000,
    parameter int unsigned P_CLEAR_WAIT = 82000,
    parameter int unsigned P_E_PULSE    = 12,
    parameter int unsigned P_NIBBLE_GAP = 50
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_char_writer_if.slave    bus,
    output logic                oInitDone,
    output logic                oLCD_Enabled,
    output logic                oLCD_RegisterSelect,
    output logic                oLCD_StrataFlashControl,
    output logic                oLCD_ReadWrite,
    output logic [3:0]          oLCD_Data
);

    localparam int CW           = 24;
    localparam int SETUP_CYCLES = 2;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_INIT4,
        ST_CFG,
        ST_IDLE,
        ST_BYTE_HI,
        ST_BYTE_LO
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_WAIT
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cfg_idx_q, cfg_idx_d;
    logic            half_q, half_d;          // 0 = upper nibble of a CFG byte
    logic            byte_rs_q, byte_rs_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            init_done_q, init_done_d;
    logic            lcd_e_q, lcd_e_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic [3:0]      lcd_data_q, lcd_data_d;

    logic            advance;
    logic            start_step;
    logic [31:0]     cnt_inc;
    logic [31:0]     wait_len;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h28;   // 4-bit bus, 2 lines, 5x8 font
            2'd1:    b = 8'h06;   // entry mode: increment, no shift
            2'd2:    b = 8'h0C;   // display on, cursor off
            default: b = 8'h01;   // clear display
        endcase
        return b;
    endfunction

    // Clear and home need the long execution time.
    function automatic logic is_slow(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02);
    endfunction

    function automatic logic [3:0] step_nibble(input state_t st, input logic [1:0] idx,
                                               input logic half, input logic [7:0] b);
        logic [3:0] n;
        logic [7:0] c;
        c = cfg_byte(idx);
        case (st)
            ST_INIT4:   n = 4'h2;
            ST_CFG:     n = half ? c[3:0] : c[7:4];
            ST_BYTE_HI: n = b[7:4];
            ST_BYTE_LO: n = b[3:0];
            default:    n = 4'h3;
        endcase
        return n;
    endfunction

    // Wait that follows the nibble of the current step.
    function automatic logic [31:0] step_wait(input state_t st, input logic [1:0] idx,
                                              input logic half, input logic rs,
                                              input logic [7:0] b);
        logic [31:0] w;
        case (st)
            ST_INIT1:   w = P_INIT_LONG;
            ST_INIT2:   w = P_INIT_SHORT;
            ST_CFG:     w = !half ? P_NIBBLE_GAP
                                  : (is_slow(1'b0, cfg_byte(idx)) ? P_CLEAR_WAIT : P_CMD_WAIT);
            ST_BYTE_HI: w = P_NIBBLE_GAP;
            ST_BYTE_LO: w = is_slow(rs, b) ? P_CLEAR_WAIT : P_CMD_WAIT;
            default:    w = P_CMD_WAIT;
        endcase
        return w;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_POWERUP;
            phase_q     <= PH_WAIT;
            cnt_q       <= '0;
            cfg_idx_q   <= '0;
            half_q      <= 1'b0;
            byte_rs_q   <= 1'b0;
            byte_data_q <= '0;
            init_done_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            cfg_idx_q   <= cfg_idx_d;
            half_q      <= half_d;
            byte_rs_q   <= byte_rs_d;
            byte_data_q <= byte_data_d;
            init_done_q <= init_done_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        cfg_idx_d   = cfg_idx_q;
        half_d      = half_q;
        byte_rs_d   = byte_rs_q;
        byte_data_d = byte_data_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        advance     = 1'b0;
        start_step  = 1'b0;
        cnt_inc     = 32'(cnt_q) + 32'd1;
        wait_len    = step_wait(state_q, cfg_idx_q, half_q, byte_rs_q, byte_data_q);

        case (state_q)
            ST_POWERUP: begin
                if (cnt_inc >= P_POWERUP) begin
                    state_d    = ST_INIT1;
                    start_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.iValid) begin
                    byte_rs_d   = bus.iRS;
                    byte_data_d = bus.iData;
                    state_d     = ST_BYTE_HI;
                    start_step  = 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                            phase_d = PH_PULSE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    PH_PULSE: begin
                        if (cnt_inc >= P_E_PULSE) begin
                            phase_d = PH_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    PH_HOLD: begin
                        // A zero-length wait skips straight to the next step.
                        if (wait_len == 32'd0) begin
                            advance = 1'b1;
                        end else begin
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        if (cnt_inc >= wait_len) begin
                            advance = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        endcase

        if (advance) begin
            case (state_q)
                ST_INIT1: state_d = ST_INIT2;
                ST_INIT2: state_d = ST_INIT3;
                ST_INIT3: state_d = ST_INIT4;
                ST_INIT4: begin
                    state_d   = ST_CFG;
                    cfg_idx_d = '0;
                    half_d    = 1'b0;
                end
                ST_CFG: begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (cfg_idx_q == 2'd3) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                        half_d    = 1'b0;
                    end
                end
                ST_BYTE_HI: state_d = ST_BYTE_LO;
                default:    state_d = ST_IDLE;
            endcase
            start_step = (state_d != ST_IDLE);
        end

        // RS/data are only loaded here, at the start of SETUP.
        if (start_step) begin
            phase_d    = PH_SETUP;
            cnt_d      = '0;
            lcd_data_d = step_nibble(state_d, cfg_idx_d, half_d, byte_data_d);
            lcd_rs_d   = (state_d == ST_BYTE_HI || state_d == ST_BYTE_LO) ? byte_rs_d : 1'b0;
        end

        lcd_e_d = (phase_d == PH_PULSE) && (state_d != ST_POWERUP) && (state_d != ST_IDLE);
    end

    assign bus.oReady              = (state_q == ST_IDLE);
    assign oInitDone               = init_done_q;
    assign oLCD_Enabled            = lcd_e_q;
    assign oLCD_RegisterSelect     = lcd_rs_q;
    assign oLCD_Data               = lcd_data_q;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
module tb_lcd_char_writer;

    localparam int unsigned T_POWERUP = 20;
    localparam int unsigned T_LONG    = 10;
    localparam int unsigned T_SHORT   = 5;
    localparam int unsigned T_CMD     = 4;
    localparam int unsigned T_CLEAR   = 8;
    localparam int unsigned T_E       = 3;
    localparam int unsigned T_GAP     = 2;
    localparam int          NIB_T     = 2 + T_E + 1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       init_done, lcd_e, lcd_rs, lcd_sf, lcd_rw;
    logic [3:0] lcd_data;

    always #5 Clock = ~Clock;

    lcd_char_writer_if bus();

    lcd_char_writer #(
        .P_POWERUP(T_POWERUP), .P_INIT_LONG(T_LONG), .P_INIT_SHORT(T_SHORT),
        .P_CMD_WAIT(T_CMD), .P_CLEAR_WAIT(T_CLEAR), .P_E_PULSE(T_E),
        .P_NIBBLE_GAP(T_GAP)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus),
        .oInitDone(init_done),
        .oLCD_Enabled(lcd_e),
        .oLCD_RegisterSelect(lcd_rs),
        .oLCD_StrataFlashControl(lcd_sf),
        .oLCD_ReadWrite(lcd_rw),
        .oLCD_Data(lcd_data)
    );

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         width;
    } pulse_t;

    pulse_t pulses[$];
    int checks   = 0;
    int failures = 0;
    int stab_err = 0;
    int const_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records every E pulse with its RS/data and width.
    logic   prev_e = 1'b0;
    pulse_t cur;
    always @(negedge Clock) begin
        if (lcd_rw !== 1'b0 || lcd_sf !== 1'b1) const_err++;
        if (lcd_e === 1'b1) begin
            if (!prev_e) begin
                cur.rs = lcd_rs; cur.nib = lcd_data; cur.width = 1;
            end else begin
                cur.width++;
                if (lcd_rs !== cur.rs || lcd_data !== cur.nib) stab_err++;
            end
        end else if (prev_e) begin
            pulses.push_back(cur);
        end
        prev_e = (lcd_e === 1'b1);
    end

    // Reference model helpers
    function automatic bit slow_cmd(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && (d == 8'h01 || d == 8'h02);
    endfunction

    function automatic int byte_time(input logic rs, input logic [7:0] d);
        return 2 * NIB_T + T_GAP + (slow_cmd(rs, d) ? T_CLEAR : T_CMD);
    endfunction

    task automatic expect_nibble(input string tag, input logic rs, input logic [3:0] nib);
        pulse_t p;
        p.rs = 1'bx; p.nib = 4'hx; p.width = -1;
        if (pulses.size() > 0) p = pulses.pop_front();
        check({tag, "_nib"}, {27'd0, p.rs, p.nib}, {27'd0, rs, nib});
        check({tag, "_ewidth"}, p.width, T_E);
    endtask

    task automatic wait_ready(input int max, input bit junk, output int n);
        n = 0;
        while (bus.oReady !== 1'b1 && n < max) begin
            if (junk) begin
                bus.iValid = 1'($urandom_range(0, 1));
                bus.iRS    = 1'($urandom);
                bus.iData  = 8'($urandom);
            end
            @(negedge Clock);
            n++;
        end
        if (junk) bus.iValid = 1'b0;
    endtask

    // Waits for init after Reset release; optionally holds iValid high meanwhile.
    task automatic run_init(input bit hold_valid);
        logic [7:0] cfg[4];
        int n, exp_t, early_ready;
        cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
        n = 0; early_ready = 0;
        bus.iValid = hold_valid; bus.iRS = 1'b1; bus.iData = 8'h55;
        while (init_done !== 1'b1 && n < 2000) begin
            @(negedge Clock);
            n++;
            if (init_done !== 1'b1 && bus.oReady !== 1'b0) early_ready++;
        end
        bus.iValid = 1'b0;
        exp_t = T_POWERUP + 4 * NIB_T + T_LONG + T_SHORT + 2 * T_CMD;
        foreach (cfg[i]) exp_t += byte_time(1'b0, cfg[i]);
        check("init_latency", n, exp_t);
        check("ready_before_init", early_ready, 0);
        check("ready_at_init", bus.oReady, 1);
        check("init_pulse_count", pulses.size(), 12);
        expect_nibble("init1", 1'b0, 4'h3);
        expect_nibble("init2", 1'b0, 4'h3);
        expect_nibble("init3", 1'b0, 4'h3);
        expect_nibble("init4", 1'b0, 4'h2);
        foreach (cfg[i]) begin
            expect_nibble("cfg_hi", 1'b0, cfg[i][7:4]);
            expect_nibble("cfg_lo", 1'b0, cfg[i][3:0]);
        end
        $display("txn init latency=%0d", n);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input bit junk);
        int n;
        bus.iValid = 1'b1; bus.iRS = rs; bus.iData = d;
        @(negedge Clock);
        check("ready_drop", bus.oReady, 0);
        bus.iValid = 1'b0; bus.iRS = ~rs; bus.iData = ~d;
        wait_ready(1000, junk, n);
        check("byte_latency", n, byte_time(rs, d));
        check("byte_pulse_count", pulses.size(), 2);
        expect_nibble("byte_hi", rs, d[7:4]);
        expect_nibble("byte_lo", rs, d[3:0]);
        $display("txn write rs=%0d data=%02h junk=%0d latency=%0d", rs, d, junk, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic rs;
        logic [7:0] d;
        bus.iValid = 1'b0; bus.iRS = 1'b0; bus.iData = 8'h00;

        // Reset held 3 cycles with outputs at reset values
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("reset_outputs", {24'd0, bus.oReady, init_done, lcd_e, lcd_rs, lcd_data},
                  {24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        end
        Reset = 1'b0;
        run_init(1'b1);

        // Directed bytes
        do_write(1'b1, 8'h41, 1'b0);
        do_write(1'b0, 8'h01, 1'b0);
        do_write(1'b0, 8'h80, 1'b0);
        do_write(1'b0, 8'h02, 1'b1);
        do_write(1'b1, 8'h01, 1'b1);

        // Randomized bytes with random idle gaps and junk requests while busy
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 2));
            end
            do_write(rs, d, 1'($urandom_range(0, 1)));
        end

        // Back-to-back with iValid held high
        bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
        @(negedge Clock);
        check("b2b_ready_drop1", bus.oReady, 0);
        bus.iData = 8'h69;
        wait_ready(1000, 1'b0, n);
        check("b2b_latency1", n, byte_time(1'b1, 8'h48));
        @(negedge Clock);
        check("b2b_ready_drop2", bus.oReady, 0);
        bus.iValid = 1'b0;
        wait_ready(1000, 1'b0, n);
        check("b2b_latency2", n, byte_time(1'b1, 8'h69));
        check("b2b_pulse_count", pulses.size(), 4);
        expect_nibble("b2b_0", 1'b1, 4'h4);
        expect_nibble("b2b_1", 1'b1, 4'h8);
        expect_nibble("b2b_2", 1'b1, 4'h6);
        expect_nibble("b2b_3", 1'b1, 4'h9);
        $display("txn back_to_back 48,69");

        // Reset during the E pulse of the upper nibble
        bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h5A;
        @(negedge Clock);
        bus.iValid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("midbyte_e_seen", lcd_e, 1);
        Reset = 1'b1;
        @(negedge Clock);
        check("midbyte_reset_outputs", {29'd0, lcd_e, bus.oReady, init_done}, 32'd0);
        @(negedge Clock);
        pulses.delete();
        Reset = 1'b0;
        run_init(1'b0);
        do_write(1'b1, 8'h7E, 1'b0);
        $display("txn reset_mid_byte");

        check("rw_sf_constant", const_err, 0);
        check("rs_data_stable_during_e", stab_err, 0);
        repeat (5) @(negedge Clock);
        check("no_stray_pulses", pulses.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_char_writer.md
Name: lcd_char_writer

Overview:
Downstream consumer of the MiniAlu datapath. It accepts byte-wide command/character writes over a valid/ready handshake and drives the 4-bit HD44780-compatible character LCD on the starter board (write-only, StrataFlash disabled). Out of reset it runs the power-on init and configuration sequence autonomously. It accepts no user writes until init completes.

Parameters:
P_POWERUP, 750000, cycles waited after reset before the first init nibble (15 ms at 50 MHz)
P_INIT_LONG, 205000, wait after first 0x3 init nibble (4.1 ms)
P_INIT_SHORT, 5000, wait after second 0x3 init nibble (100 us)
P_CMD_WAIT, 2000, wait after third 0x3 nibble, after 0x2 nibble, and after every full byte (40 us)
P_CLEAR_WAIT, 82000, wait after a byte with RS=0 and value 0x01 or 0x02 (clear/home, 1.64 ms)
P_E_PULSE, 12, cycles oLCD_Enabled held high per nibble (>=230 ns)
P_NIBBLE_GAP, 50, wait between upper and lower nibble of one byte (1 us)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
iValid  input  1  write request; qualifies iRS and iData
iRS  input  1  register select for the request: 0 = command, 1 = data
iData  input  8  byte to write
oReady  output  1  high when a request can be accepted this cycle
oInitDone  output  1  high once power-on init and configuration have finished; stays high until Reset
oLCD_Enabled  output  1  LCD E strobe
oLCD_RegisterSelect  output  1  LCD RS
oLCD_StrataFlashControl  output  1  SF_CE0; constant 1
oLCD_ReadWrite  output  1  LCD R/W; constant 0 (write only)
oLCD_Data  output  4  LCD DB[7:4]

Behaviour:
- Reset values: oReady=0, oInitDone=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oLCD_StrataFlashControl=1, oLCD_ReadWrite=0. The main FSM returns to POWERUP and all counters clear.
- Reset asserted mid-operation aborts everything immediately. E goes low the same edge, any pending byte is dropped, and init restarts from POWERUP.
- Nibble-write micro-sequence, shared by all writes:
  - SETUP: 2 cycles. RS and data driven, E=0.
  - PULSE: P_E_PULSE cycles. E=1, RS and data held stable.
  - HOLD: 1 cycle. E=0, RS and data held.
  - Then the post-nibble wait set by the caller.
  - RS and data change only in SETUP.
- Main FSM states:
  - POWERUP: wait P_POWERUP cycles.
  - INIT1: nibble 0x3 (RS=0), then wait P_INIT_LONG.
  - INIT2: nibble 0x3, then wait P_INIT_SHORT.
  - INIT3: nibble 0x3, then wait P_CMD_WAIT.
  - INIT4: nibble 0x2, then wait P_CMD_WAIT.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01 in that order, all RS=0, using the byte rule below. The 0x01 uses P_CLEAR_WAIT.
  - IDLE: oInitDone=1, oReady=1.
  - BYTE_HI: upper nibble, then wait P_NIBBLE_GAP.
  - BYTE_LO: lower nibble, then wait P_CMD_WAIT, or P_CLEAR_WAIT if RS=0 and the byte is 0x01 or 0x02.
  - BYTE_LO returns to IDLE.
- Handshake:
  - A transfer occurs on a rising edge where iValid=1 and oReady=1. iRS and iData are latched internally on that edge.
  - oReady drops on that same edge and stays 0 until the FSM is back in IDLE.
  - oReady is combinationally high only in IDLE; it does not depend on iValid.
  - iValid while oReady=0 is ignored; nothing is queued.
  - Inputs may change freely after acceptance.
- Byte latency: an accepted byte finishes, and oReady returns to 1, exactly (2+P_E_PULSE+1)*2 + P_NIBBLE_GAP + wait cycles after acceptance, where wait is P_CMD_WAIT or P_CLEAR_WAIT. There are no idle gaps between states.
- Wait counters use at least 20 bits. A wait of N holds exactly N cycles. A parameter value of 0 means no wait cycle.
- oInitDone rises on entry to IDLE the first time and stays high until Reset.

Test Plan:
- Reset scenario, all wait parameters reduced (P_POWERUP=20, P_INIT_LONG=10, P_INIT_SHORT=5, P_CMD_WAIT=4, P_CLEAR_WAIT=8, P_E_PULSE=3, P_NIBBLE_GAP=2): hold Reset 3 cycles, then release.
  - Exactly 12 E pulses occur before oInitDone=1.
  - Nibble sequence is 3,3,3,2,2,8,0,6,0,C,0,1, all with RS=0.
  - Outputs hold their reset values while Reset=1.
- Data write after init: iValid=1, iRS=1, iData=0x41 for 1 cycle.
  - oReady drops the next edge.
  - E pulses carry 0x4 then 0x1, each with RS=1 and E high for 3 cycles.
  - oReady returns after (2+3+1)*2+2+4=18 cycles.
- Clear timing: command 0x01 with RS=0.
  - oReady returns after 12+2+8=22 cycles.
  - Command 0x80 returns after 18 cycles.
- Back-to-back and ignored requests: hold iValid=1 continuously with 0x48 then 0x69.
  - Exactly one byte is accepted per IDLE visit.
  - iValid during busy is not lost or duplicated; the data captured at the accept edge is the data written.
  - iValid=1 before oInitDone produces no extra E pulse.
- Reset mid-byte: assert Reset during the PULSE phase of BYTE_HI.
  - E=0 on the next edge.
  - oReady=0 and oInitDone=0.
  - Init sequence restarts from POWERUP and completes normally.
- Constant outputs: across all tests, oLCD_ReadWrite is always 0 and oLCD_StrataFlashControl is always 1. RS and data never change while E=1.
